// File: rtl/uart_axi_pkg.sv
// uart_axi_pkg: opcodes, response bytes and FSM states shared by the UART-to-AXI-lite bridge
package uart_axi_pkg;
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, AW_W, WAIT_B, AR, WAIT_R, SEND} state_t;
endpackage

// File: rtl/byte_shift_tx.sv
// byte_shift_tx: parallel-load MSB-first serializer emitting 1 or 4 bytes with valid/ready
module byte_shift_tx (
  input  logic        axi_aclk,
  input  logic        axi_resetn,
  input  logic        load,
  input  logic        load_four,
  input  logic [31:0] load_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);
  logic [31:0] sr;
  logic [2:0]  cnt;
  logic        fire;
  assign tx_valid = cnt != 3'd0;
  assign tx_data  = sr[31:24];
  assign fire     = tx_valid && tx_ready;
  assign done     = fire && cnt == 3'd1;
  always_ff @(posedge axi_aclk or negedge axi_resetn)
    if (!axi_resetn) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= load_data;
      cnt <= load_four ? 3'd4 : 3'd1;
    end else if (fire) begin
      sr  <= {sr[23:0], 8'h00};
      cnt <= cnt - 3'd1;
    end
endmodule

// File: rtl/uart_axi_lite_master.sv
// uart_axi_lite_master: parses UART read/write frames into single-beat AXI-lite transactions
// and returns a status byte or the read data bytes.
module uart_axi_lite_master
  import uart_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  axi_aclk,
  input  logic                  axi_resetn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic [3:0]            axi_wstrb,
  output logic                  axi_wvalid,
  output logic                  axi_wlast,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  input  logic                  axi_rlast,
  output logic                  axi_rready,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  state_t                  state, nxt;
  logic                    is_wr, aw_done, w_done, rx_fire, tx_done;
  logic                    ld, ld_four, to_hit, expire, is_wait;
  logic [31:0]             ld_data, addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [1:0]              cnt;
  logic [TW-1:0]           tmr;
  logic                    unused_rlast;
  assign unused_rlast = axi_rlast;
  assign rx_fire      = rx_valid && rx_ready;
  assign is_wait      = state == AW_W || state == WAIT_B || state == AR || state == WAIT_R;
  assign expire       = tmr == TW'(TIMEOUT_CYCLES - 1);
  assign axi_awaddr   = ADDR_WIDTH'(addr_q);
  assign axi_araddr   = ADDR_WIDTH'(addr_q);
  assign axi_wdata    = wdata_q;
  assign axi_wstrb    = 4'hF;
  always_ff @(posedge axi_aclk or negedge axi_resetn)
    if (!axi_resetn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt     = state;
    ld      = 1'b0;
    ld_four = 1'b0;
    ld_data = {RSP_ERR, 24'h0};
    to_hit  = 1'b0;
    case (state)
      IDLE:     if (rx_fire) begin
        if (rx_data == OP_WR || rx_data == OP_RD) nxt = GET_ADDR;
        else begin
          nxt     = SEND;
          ld      = 1'b1;
          ld_data = {RSP_BAD, 24'h0};
        end
      end
      GET_ADDR: if (rx_fire && cnt == 2'd3) nxt = is_wr ? GET_DATA : AR;
      GET_DATA: if (rx_fire && cnt == 2'd3) nxt = AW_W;
      AW_W:     if ((aw_done || axi_awready) && (w_done || axi_wready)) nxt = WAIT_B;
                else if (expire) to_hit = 1'b1;
      WAIT_B:   if (axi_bvalid) begin
        nxt     = SEND;
        ld      = 1'b1;
        ld_data = {axi_bresp == 2'b00 ? RSP_OK : RSP_ERR, 24'h0};
      end else if (expire) to_hit = 1'b1;
      AR:       if (axi_arready) nxt = WAIT_R;
                else if (expire) to_hit = 1'b1;
      WAIT_R:   if (axi_rvalid) begin
        nxt     = SEND;
        ld      = 1'b1;
        ld_four = axi_rresp == 2'b00;
        ld_data = axi_rresp == 2'b00 ? 32'(axi_rdata) : {RSP_ERR, 24'h0};
      end else if (expire) to_hit = 1'b1;
      SEND:     if (tx_done) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    if (to_hit) begin
      nxt = SEND;
      ld  = 1'b1;
    end
  end
  always_comb begin
    rx_ready    = axi_resetn && (state == IDLE || state == GET_ADDR || state == GET_DATA);
    axi_awvalid = state == AW_W && !aw_done;
    axi_wvalid  = state == AW_W && !w_done;
    axi_wlast   = axi_wvalid;
    axi_bready  = state == WAIT_B;
    axi_arvalid = state == AR;
    axi_rready  = state == WAIT_R;
    busy        = state != IDLE;
  end
  always_ff @(posedge axi_aclk or negedge axi_resetn)
    if (!axi_resetn) begin
      is_wr       <= 1'b0;
      cnt         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      tmr         <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (rx_fire && state == IDLE) is_wr <= rx_data == OP_WR;
      if (rx_fire && state != IDLE) cnt <= cnt + 2'd1;
      if (rx_fire && state == GET_ADDR) addr_q <= {addr_q[23:0], rx_data};
      if (rx_fire && state == GET_DATA) wdata_q <= {wdata_q[DATA_WIDTH-9:0], rx_data};
      aw_done <= state == AW_W && nxt == AW_W && (aw_done || axi_awready);
      w_done  <= state == AW_W && nxt == AW_W && (w_done || axi_wready);
      tmr     <= (is_wait && nxt == state) ? tmr + TW'(1) : '0;
      if (to_hit) timeout_err <= 1'b1;
    end
  byte_shift_tx u_tx (
    .axi_aclk  (axi_aclk),
    .axi_resetn(axi_resetn),
    .load      (ld),
    .load_four (ld_four),
    .load_data (ld_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (tx_done)
  );
endmodule

// File: tb/tb_uart_axi_lite_master.sv
// tb_uart_axi_lite_master: directed frame-level checks of the UART-to-AXI-lite bridge
module tb_uart_axi_lite_master;
  logic        clk = 1'b0, rstn = 1'b0;
  logic [7:0]  rx_data = '0, tx_data;
  logic        rx_valid = 1'b0, rx_ready, tx_valid, tx_ready = 1'b0;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [3:0]  wstrb;
  logic        awvalid, awready = 1'b0, wvalid, wlast, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic        rvalid = 1'b0, rlast = 1'b0, rready, busy, timeout_err;
  int          n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  uart_axi_lite_master dut (
    .axi_aclk(clk), .axi_resetn(rstn),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wlast(wlast), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rlast(rlast), .axi_rready(rready),
    .busy(busy), .timeout_err(timeout_err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      tick();
      n++;
    end
    if (!rx_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_accept byte %h: rx_ready got 0 exp 1", b);
    end
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask
  task automatic recv_byte(output logic [7:0] got, output logic ok);
    int n = 0;
    while (!tx_valid && n < 2000) begin
      tick();
      n++;
    end
    ok  = tx_valid;
    got = tx_data;
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask
  task automatic test_reset;
    rstn = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({rx_ready, tx_valid, awvalid, wvalid, bready, arvalid, rready, busy, timeout_err} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got %b exp 000000000",
               {rx_ready, tx_valid, awvalid, wvalid, bready, arvalid, rready, busy, timeout_err});
    end
    n_cmp++;
    if ({awaddr, araddr, wdata, tx_data} !== 104'h0) begin
      n_err++;
      $display("FAIL reset_data got aw=%h ar=%h w=%h tx=%h exp all 0", awaddr, araddr, wdata, tx_data);
    end
    rstn = 1'b1;
    tick();
    n_cmp++;
    if ({rx_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release got rx_ready,busy=%b exp 10", {rx_ready, busy});
    end
  endtask
  task automatic test_write(input logic [31:0] a, input logic [31:0] d);
    logic [7:0] got;
    logic       ok;
    awready = 1'b1;
    wready  = 1'b1;
    send_byte(8'h57);
    send_word(a);
    send_word(d);
    n_cmp++;
    if ({awvalid, wvalid, wlast, wstrb, awaddr, wdata} !== {3'b111, 4'hF, a, d}) begin
      n_err++;
      $display("FAIL wr_aw_w got v=%b%b%b strb=%h addr=%h data=%h exp v=111 strb=f addr=%h data=%h",
               awvalid, wvalid, wlast, wstrb, awaddr, wdata, a, d);
    end
    tick();
    n_cmp++;
    if ({awvalid, wvalid, bready} !== 3'b001) begin
      n_err++;
      $display("FAIL wr_wait_b got aw,w,bready=%b exp 001", {awvalid, wvalid, bready});
    end
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b1;
    bresp   = 2'b00;
    tick();
    bvalid = 1'b0;
    recv_byte(got, ok);
    n_cmp++;
    if ({ok, got, busy} !== {1'b1, 8'h4B, 1'b0}) begin
      n_err++;
      $display("FAIL wr_resp got ok=%b byte=%h busy=%b exp ok=1 byte=4b busy=0", ok, got, busy);
    end
  endtask
  task automatic test_read;
    logic [7:0]  got;
    logic        ok;
    logic [31:0] exp = 32'hDEADBEEF;
    arready = 1'b1;
    send_byte(8'h52);
    send_word(32'h24);
    n_cmp++;
    if ({arvalid, araddr} !== {1'b1, 32'h24}) begin
      n_err++;
      $display("FAIL rd_ar got arvalid=%b araddr=%h exp 1 00000024", arvalid, araddr);
    end
    tick();
    arready = 1'b0;
    n_cmp++;
    if ({arvalid, rready} !== 2'b01) begin
      n_err++;
      $display("FAIL rd_wait_r got arvalid,rready=%b exp 01", {arvalid, rready});
    end
    rvalid = 1'b1;
    rdata  = exp;
    rresp  = 2'b00;
    tick();
    rvalid = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      recv_byte(got, ok);
      n_cmp++;
      if ({ok, got} !== {1'b1, exp[i*8 +: 8]}) begin
        n_err++;
        $display("FAIL rd_byte%0d got ok=%b byte=%h exp ok=1 byte=%h", 3 - i, ok, got, exp[i*8 +: 8]);
      end
    end
    n_cmp++;
    if ({tx_valid, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL rd_end got tx_valid,busy=%b exp 00", {tx_valid, busy});
    end
  endtask
  task automatic test_bad_opcode;
    logic [7:0] got;
    logic       ok;
    send_byte(8'h41);
    recv_byte(got, ok);
    n_cmp++;
    if ({ok, got, busy} !== {1'b1, 8'h3F, 1'b0}) begin
      n_err++;
      $display("FAIL bad_op got ok=%b byte=%h busy=%b exp ok=1 byte=3f busy=0", ok, got, busy);
    end
    test_write(32'h0000_0100, 32'hA5A5_5A5A);
  endtask
  task automatic test_rresp_err;
    logic [7:0] got;
    logic       ok;
    arready = 1'b1;
    send_byte(8'h52);
    send_word(32'h8);
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rresp   = 2'b10;
    rdata   = 32'h1234_5678;
    tick();
    rvalid = 1'b0;
    rresp  = 2'b00;
    recv_byte(got, ok);
    n_cmp++;
    if ({ok, got, tx_valid, busy, timeout_err} !== {1'b1, 8'h45, 3'b000}) begin
      n_err++;
      $display("FAIL rresp_err got ok=%b byte=%h tx_valid=%b busy=%b terr=%b exp 1 45 0 0 0",
               ok, got, tx_valid, busy, timeout_err);
    end
  endtask
  task automatic test_reset_mid;
    logic [7:0]  got;
    logic        ok;
    logic        bad = 1'b0;
    logic [31:0] exp = 32'h0102_0304;
    send_byte(8'h52);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rstn = 1'b0;
    tick();
    n_cmp++;
    if ({busy, rx_ready, arvalid, tx_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_reset got busy,rx_ready,arvalid,tx_valid=%b exp 0000", {busy, rx_ready, arvalid, tx_valid});
    end
    rstn = 1'b1;
    tick();
    arready = 1'b1;
    send_byte(8'h52);
    send_byte(8'h00);
    n_cmp++;
    if (arvalid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_stale_frame got arvalid=%b exp 0", arvalid);
    end
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h40);
    n_cmp++;
    if ({arvalid, araddr} !== {1'b1, 32'h40}) begin
      n_err++;
      $display("FAIL mid_new_addr got arvalid=%b araddr=%h exp 1 00000040", arvalid, araddr);
    end
    tick();
    arready = 1'b0;
    rvalid  = 1'b1;
    rdata   = exp;
    tick();
    rvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ({tx_valid, tx_data, rx_ready} !== {1'b1, 8'h01, 1'b0}) bad = 1'b1;
      tick();
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_err++;
      $display("FAIL tx_stall got unstable tx or rx_ready high (now v=%b d=%h rr=%b) exp v=1 d=01 rr=0",
               tx_valid, tx_data, rx_ready);
    end
    for (int i = 3; i >= 0; i--) begin
      recv_byte(got, ok);
      n_cmp++;
      if ({ok, got} !== {1'b1, exp[i*8 +: 8]}) begin
        n_err++;
        $display("FAIL stall_byte%0d got ok=%b byte=%h exp ok=1 byte=%h", 3 - i, ok, got, exp[i*8 +: 8]);
      end
    end
  endtask
  task automatic test_timeout;
    logic [7:0] got;
    logic       ok;
    int         n = 0;
    awready = 1'b1;
    wready  = 1'b1;
    send_byte(8'h57);
    send_word(32'h20);
    send_word(32'h55);
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    while (bready && n < 2000) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n !== 1024) begin
      n_err++;
      $display("FAIL timeout_len got %0d bready cycles exp 1024", n);
    end
    n_cmp++;
    if ({timeout_err, busy, tx_valid, tx_data} !== {3'b111, 8'h45}) begin
      n_err++;
      $display("FAIL timeout_state got terr=%b busy=%b tx_valid=%b tx=%h exp 1 1 1 45",
               timeout_err, busy, tx_valid, tx_data);
    end
    recv_byte(got, ok);
    n_cmp++;
    if ({ok, got, busy, timeout_err} !== {1'b1, 8'h45, 2'b01}) begin
      n_err++;
      $display("FAIL timeout_resp got ok=%b byte=%h busy=%b terr=%b exp 1 45 0 1", ok, got, busy, timeout_err);
    end
  endtask
  initial begin
    test_reset();
    test_write(32'h10, 32'h3);
    test_read();
    test_bad_opcode();
    test_rresp_err();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
